// File: rtl/invader_pkg.sv
// Shared types for the invader formation mover.
// State encoding, fixed-point position type and speed level type.
package invader_pkg;

  localparam int DEF_FRAC_BITS = 6;

  typedef logic signed [31:0] fixpos_t;
  typedef logic [2:0] level_t;

  typedef enum logic [2:0] {
    IDLE,
    MOV_RGT,
    DROP_L,
    MOV_LFT,
    DROP_R,
    LANDED
  } state_t;

endpackage

// File: rtl/invader_speed_ctrl.sv
// Saturating speed level and horizontal step per frame.
// INVADER_MARCH_STEP_EN selects paced whole-pixel steps instead of smooth speed.
module invader_speed_ctrl
  import invader_pkg::*;
#(
  parameter int BASE_X_SPEED = 60,
  parameter int SPEED_INC    = 16,
  parameter int MAX_LEVEL    = 7
`ifdef INVADER_MARCH_STEP_EN
  ,
  parameter int FRAC_BITS    = DEF_FRAC_BITS,
  parameter int MARCH_PIX    = 4,
  parameter int MARCH_PERIOD = 12
`endif
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    restart,
  input  logic    speedUp,
`ifdef INVADER_MARCH_STEP_EN
  input  logic    startOfFrame,
  input  logic    freeze,
  input  logic    marching,
`endif
  output level_t  level,
  output fixpos_t hStep
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (restart) begin
      level <= '0;
    end else if (speedUp && (level < level_t'(MAX_LEVEL))) begin
      level <= level + 3'd1;
    end
  end

`ifdef INVADER_MARCH_STEP_EN
  localparam fixpos_t STEP_FIX = fixpos_t'(MARCH_PIX) <<< FRAC_BITS;

  logic [7:0] paceCnt;
  logic [7:0] period;
  logic       stepNow;

  // frames per step shrinks with level but never below one
  always_comb begin
    period = 8'd1;
    if (MARCH_PERIOD > int'(level) + 1) begin
      period = 8'(MARCH_PERIOD - int'(level));
    end
  end

  assign stepNow = (paceCnt + 8'd1) >= period;
  assign hStep   = stepNow ? STEP_FIX : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paceCnt <= '0;
    end else if (restart) begin
      paceCnt <= '0;
    end else if (startOfFrame && marching && !freeze) begin
      paceCnt <= stepNow ? 8'd0 : paceCnt + 8'd1;
    end
  end
`else
  assign hStep = fixpos_t'(BASE_X_SPEED)
               + fixpos_t'(level) * fixpos_t'(SPEED_INC);
`endif

endmodule

// File: rtl/invader_formation_mover.sv
// Formation corner motion: march, drop at edges, reverse, land.
// Define INVADER_MARCH_STEP_EN for jerky whole-pixel marching.
module invader_formation_mover
  import invader_pkg::*;
#(
  parameter int INIT_X       = 20,
  parameter int INIT_Y       = 20,
  parameter int FRAC_BITS    = DEF_FRAC_BITS,
  parameter int LEFT_BOUND   = 0,
  parameter int RIGHT_BOUND  = 639,
  parameter int BOTTOM_Y     = 400,
  parameter int BASE_X_SPEED = 60,
  parameter int SPEED_INC    = 16,
  parameter int MAX_LEVEL    = 7,
  parameter int DROP_PIX     = 16,
  parameter int DROP_SPEED   = 64,
  parameter int MARCH_PIX    = 4,
  parameter int MARCH_PERIOD = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start,
  input  logic        restart,
  input  logic        speedUp,
  input  logic        chgDir,
  input  logic        freeze,
  input  logic [10:0] formationWidth,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        dirLeft,
  output logic        dropping,
  output logic        edgeHit,
  output logic        reachedBottom,
  output logic [2:0]  speedLevel
);

  localparam fixpos_t X0      = fixpos_t'(INIT_X) <<< FRAC_BITS;
  localparam fixpos_t Y0      = fixpos_t'(INIT_Y) <<< FRAC_BITS;
  localparam fixpos_t LFIX    = fixpos_t'(LEFT_BOUND) <<< FRAC_BITS;
  localparam fixpos_t RFIX    = fixpos_t'(RIGHT_BOUND) <<< FRAC_BITS;
  localparam fixpos_t BFIX    = fixpos_t'(BOTTOM_Y) <<< FRAC_BITS;
  localparam fixpos_t DROPFIX = fixpos_t'(DROP_PIX) <<< FRAC_BITS;
`ifdef INVADER_MARCH_STEP_EN
  localparam fixpos_t DSTEP   = DROPFIX;
`else
  localparam fixpos_t DSTEP   = fixpos_t'(DROP_SPEED);
`endif

  state_t  state, stateN;
  fixpos_t x, xN, y, yN, acc, accN;
  fixpos_t nx, wFix, rClamp, hStep;
  logic    dirN, edgeN, botN;
  level_t  level;

  invader_speed_ctrl #(
    .BASE_X_SPEED(BASE_X_SPEED),
    .SPEED_INC(SPEED_INC),
    .MAX_LEVEL(MAX_LEVEL)
`ifdef INVADER_MARCH_STEP_EN
    ,
    .FRAC_BITS(FRAC_BITS),
    .MARCH_PIX(MARCH_PIX),
    .MARCH_PERIOD(MARCH_PERIOD)
`endif
  ) uSpeed (
    .clk(clk),
    .reset(reset),
    .restart(restart),
    .speedUp(speedUp),
`ifdef INVADER_MARCH_STEP_EN
    .startOfFrame(startOfFrame),
    .freeze(freeze),
    .marching((state == MOV_RGT) || (state == MOV_LFT)),
`endif
    .level(level),
    .hStep(hStep)
  );

  assign speedLevel = level;
  assign topLeftX   = 11'(x >>> FRAC_BITS);
  assign topLeftY   = 11'(y >>> FRAC_BITS);
  assign dropping   = (state == DROP_L) || (state == DROP_R);

  // an over-wide formation pins to the left bound instead of underflowing
  always_comb begin
    wFix   = fixpos_t'({21'b0, formationWidth}) <<< FRAC_BITS;
    rClamp = RFIX - wFix;
    if (rClamp < LFIX) begin
      rClamp = LFIX;
    end
  end

  always_comb begin
    stateN = state;
    xN     = x;
    yN     = y;
    accN   = acc;
    dirN   = dirLeft;
    edgeN  = 1'b0;
    botN   = reachedBottom;
    nx     = x;
    if (restart) begin
      stateN = IDLE;
      xN     = X0;
      yN     = Y0;
      accN   = '0;
      dirN   = 1'b0;
      botN   = 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        stateN = MOV_RGT;
        accN   = '0;
      end
    end else if (startOfFrame && !freeze) begin
      case (state)
        MOV_RGT: begin
          nx = x + hStep;
          if (nx + wFix >= RFIX) begin
            xN     = rClamp;
            stateN = DROP_L;
          end else if (chgDir) begin
            stateN = DROP_L;
          end else begin
            xN = nx;
          end
        end
        MOV_LFT: begin
          nx = x - hStep;
          if (nx <= LFIX) begin
            xN     = LFIX;
            stateN = DROP_R;
          end else if (chgDir) begin
            stateN = DROP_R;
          end else begin
            xN = nx;
          end
        end
        DROP_L, DROP_R: begin
          if (acc + DSTEP >= DROPFIX) begin
            yN     = y + (DROPFIX - acc);
            accN   = '0;
            stateN = (state == DROP_L) ? MOV_LFT : MOV_RGT;
          end else begin
            yN   = y + DSTEP;
            accN = acc + DSTEP;
          end
        end
        default: begin
        end
      endcase
      if (yN >= BFIX) begin
        yN     = BFIX;
        stateN = LANDED;
        botN   = 1'b1;
      end
      if ((stateN == DROP_L) || (stateN == DROP_R)) begin
        if ((state == MOV_RGT) || (state == MOV_LFT)) begin
          edgeN = 1'b1;
          dirN  = (stateN == DROP_L);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      x             <= X0;
      y             <= Y0;
      acc           <= '0;
      dirLeft       <= 1'b0;
      edgeHit       <= 1'b0;
      reachedBottom <= 1'b0;
    end else begin
      state         <= stateN;
      x             <= xN;
      y             <= yN;
      acc           <= accN;
      dirLeft       <= dirN;
      edgeHit       <= edgeN;
      reachedBottom <= botN;
    end
  end

endmodule

// File: tb/tb_invader_formation_mover.sv
// Scoreboard bench for invader_formation_mover (default parameters).
module tb_invader_formation_mover;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, start, restart;
  logic        speedUp, chgDir, freeze;
  logic [10:0] formationWidth, topLeftX, topLeftY;
  logic        dirLeft, dropping, edgeHit, reachedBottom;
  logic [2:0]  speedLevel;

  int nCmp = 0;
  int nBad = 0;
  int edgeCnt = 0;

  always #5 clk = ~clk;

  invader_formation_mover dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .start(start),
    .restart(restart),
    .speedUp(speedUp),
    .chgDir(chgDir),
    .freeze(freeze),
    .formationWidth(formationWidth),
    .topLeftX(topLeftX),
    .topLeftY(topLeftY),
    .dirLeft(dirLeft),
    .dropping(dropping),
    .edgeHit(edgeHit),
    .reachedBottom(reachedBottom),
    .speedLevel(speedLevel)
  );

  localparam int S_IDLE = 0, S_MR = 1, S_DL = 2;
  localparam int S_ML = 3, S_DR = 4, S_LAND = 5;

  int mX, mY, mAcc, mLvl, mSt;
  bit mDir, mBot, mFrz;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [6:0]  fl;
  } exp_t;

  exp_t sb[$];
  exp_t sbE;
  logic sofD = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] mFlags(input bit hit);
    return {mDir, (mSt == S_DL) || (mSt == S_DR), mBot, hit, 3'(mLvl)};
  endfunction

  task automatic modelInit();
    mX = 20 * 64; mY = 20 * 64; mAcc = 0; mLvl = 0;
    mSt = S_IDLE; mDir = 0; mBot = 0;
  endtask

  task automatic modelFrame(input bit chg);
    int spd, nx, ny, dy, w, rc;
    bit hit;
    exp_t e;
    hit = 0;
    w = int'(formationWidth);
    ny = mY;
    if (!mFrz && mSt != S_IDLE && mSt != S_LAND) begin
      spd = 60 + 16 * mLvl;
      if (mSt == S_MR) begin
        nx = mX + spd;
        rc = (639 - w) * 64;
        if (rc < 0) rc = 0;
        if (nx + w * 64 >= 639 * 64) begin mX = rc; mSt = S_DL; hit = 1; end
        else if (chg) begin mSt = S_DL; hit = 1; end
        else mX = nx;
      end else if (mSt == S_ML) begin
        nx = mX - spd;
        if (nx <= 0) begin mX = 0; mSt = S_DR; hit = 1; end
        else if (chg) begin mSt = S_DR; hit = 1; end
        else mX = nx;
      end else begin
        dy = 64;
        if (mAcc + dy >= 1024) begin
          dy = 1024 - mAcc;
          mAcc = 0;
          mSt = (mSt == S_DL) ? S_ML : S_MR;
        end else begin
          mAcc += dy;
        end
        ny = mY + dy;
      end
      if (ny >= 400 * 64) begin
        ny = 400 * 64; mSt = S_LAND; mBot = 1; hit = 0;
      end
      if (hit) mDir = (mSt == S_DL);
      mY = ny;
    end
    e.x = 11'(mX / 64);
    e.y = 11'(mY / 64);
    e.fl = mFlags(hit);
    sb.push_back(e);
  endtask

  always @(posedge clk) sofD <= startOfFrame;

  always @(negedge clk) begin
    if (edgeHit) edgeCnt++;
    if (sofD) begin
      if (sb.size() == 0) begin
        chk("sbEmpty", 32'd0, 32'd1);
      end else begin
        sbE = sb.pop_front();
        chk("x", 32'(topLeftX), 32'(sbE.x));
        chk("y", 32'(topLeftY), 32'(sbE.y));
        chk("flags", 32'({dirLeft, dropping, reachedBottom, edgeHit, speedLevel}),
            32'(sbE.fl));
      end
    end
  end

  task automatic frame(input bit chg);
    @(negedge clk);
    startOfFrame = 1'b1;
    chgDir = chg;
    modelFrame(chg);
    @(negedge clk);
    startOfFrame = 1'b0;
    chgDir = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame(1'b0);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    if (mSt == S_IDLE) begin mSt = S_MR; mAcc = 0; end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseRestart();
    @(negedge clk);
    restart = 1'b1;
    modelInit();
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic pulseSpeed();
    @(negedge clk);
    speedUp = 1'b1;
    if (mLvl < 7) mLvl++;
    @(negedge clk);
    speedUp = 1'b0;
  endtask

  task automatic checkNow(input string tag);
    chk({tag, "X"}, 32'(topLeftX), 32'(mX / 64));
    chk({tag, "Y"}, 32'(topLeftY), 32'(mY / 64));
    chk({tag, "F"}, 32'({dirLeft, dropping, reachedBottom, edgeHit, speedLevel}),
        32'(mFlags(1'b0)));
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; start = 1'b0; restart = 1'b0;
    speedUp = 1'b0; chgDir = 1'b0; freeze = 1'b0; mFrz = 0;
    formationWidth = 11'd100;
    modelInit();
    repeat (3) @(negedge clk);
    checkNow("rst");
    reset = 1'b0;
    pulseStart();

    // march right to the edge
    frames(553);
    chk("t1pre", 32'(dropping), 32'd0);
    frame(1'b0);
    chk("t1x", 32'(topLeftX), 32'd539);
    chk("t1drop", 32'(dropping), 32'd1);
    chk("t1edge", 32'(edgeHit), 32'd1);

    // drop, then march left
    frames(16);
    chk("t2y", 32'(topLeftY), 32'd36);
    chk("t2dir", 32'(dirLeft), 32'd1);
    chk("t2drop", 32'(dropping), 32'd0);
    chk("t2edges", 32'(edgeCnt), 32'd1);
    frame(1'b0);
    chk("t2x", 32'(topLeftX), 32'd538);

    // speed levels
    pulseRestart();
    checkNow("rstrt");
    pulseStart();
    repeat (3) pulseSpeed();
    chk("t3lvl", 32'(speedLevel), 32'd3);
    frames(64);
    chk("t3x", 32'(topLeftX), 32'd128);
    repeat (10) pulseSpeed();
    chk("t3sat", 32'(speedLevel), 32'd7);

    // forced edges until landing
    pulseRestart();
    pulseStart();
    for (int i = 0; i < 23; i++) begin
      frame(1'b1);
      frames(16);
    end
    chk("t4y388", 32'(topLeftY), 32'd388);
    frame(1'b1);
    frames(11);
    chk("t4bot0", 32'(reachedBottom), 32'd0);
    frame(1'b0);
    chk("t4bot", 32'(reachedBottom), 32'd1);
    chk("t4y", 32'(topLeftY), 32'd400);
    frames(5);
    chk("t4hold", 32'(topLeftY), 32'd400);
    pulseRestart();
    checkNow("t4rst");

    // freeze mid-march, chgDir during drop
    pulseStart();
    frames(10);
    @(negedge clk);
    freeze = 1'b1;
    mFrz = 1;
    frames(30);
    chk("t5x", 32'(topLeftX), 32'd29);
    @(negedge clk);
    freeze = 1'b0;
    mFrz = 0;
    frame(1'b0);
    chk("t5res", 32'(topLeftX), 32'd30);
    frame(1'b1);
    frame(1'b1);
    frames(15);
    chk("t5y", 32'(topLeftY), 32'd36);
    chk("t5drop", 32'(dropping), 32'd0);
    chk("t5dir", 32'(dirLeft), 32'd1);

    // async reset in the middle of DROP_R
    frame(1'b1);
    frames(5);
    chk("t6mid", 32'(dropping), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    modelInit();
    chk("t6x", 32'(topLeftX), 32'd20);
    chk("t6y", 32'(topLeftY), 32'd20);
    chk("t6drop", 32'(dropping), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulseStart();
    frame(1'b1);
    frames(16);
    chk("t6y2", 32'(topLeftY), 32'd36);
    chk("t6drop2", 32'(dropping), 32'd0);

    // formation wider than the playfield
    pulseRestart();
    formationWidth = 11'd700;
    pulseStart();
    frame(1'b0);
    chk("t7x", 32'(topLeftX), 32'd0);
    chk("t7edge", 32'(edgeHit), 32'd1);
    frames(16);
    frame(1'b0);
    chk("t7x2", 32'(topLeftX), 32'd0);
    chk("t7drop", 32'(dropping), 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/invader_formation_mover.md
Name: invader_formation_mover

Overview:
Parametrised successor to the single-formation invader motion controller. Drives the formation's top-left corner across the screen: horizontal march, fixed-pixel drop at each edge, then direction reversal. The march speed rises in discrete levels on `speedUp`, and the block flags when the formation lands. Sits between game control (start/restart/speed events) and the invader matrix/draw logic, which consumes `topLeftX`/`topLeftY`.

Parameters:
INIT_X, 20, reset/restart X position (pixels)
INIT_Y, 20, reset/restart Y position (pixels)
FRAC_BITS, 6, fixed-point fraction bits; sub-pixel scale = 2^FRAC_BITS
LEFT_BOUND, 0, leftmost allowed X of the formation's left edge (pixels)
RIGHT_BOUND, 639, rightmost allowed X of the formation's right edge (pixels)
BOTTOM_Y, 400, Y at which the formation has landed (pixels)
BASE_X_SPEED, 60, level-0 horizontal speed (sub-pixels/frame)
SPEED_INC, 16, added speed per level (sub-pixels/frame)
MAX_LEVEL, 7, saturating speed level
DROP_PIX, 16, total drop per edge hit (pixels)
DROP_SPEED, 64, vertical speed during a drop (sub-pixels/frame)
MARCH_PIX, 4, step size in march mode (pixels; optional feature only)
MARCH_PERIOD, 12, frames per step at level 0 (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-clk pulse per frame; all motion updates occur only on this cycle
start  in  1  pulse; leaves IDLE
restart  in  1  pulse; reload initial position, level 0, go to IDLE
speedUp  in  1  pulse; level += 1, saturating at MAX_LEVEL
chgDir  in  1  pulse; forces an edge event during a march state
freeze  in  1  level; holds position, state and march pacing
formationWidth  in  11  current formation width in pixels
topLeftX  out  11  integer X (fixed-point >> FRAC_BITS)
topLeftY  out  11  integer Y
dirLeft  out  1  1 = current or next march is leftward
dropping  out  1  1 in a drop state
edgeHit  out  1  one-clk pulse when a drop begins
reachedBottom  out  1  sticky landed flag
speedLevel  out  3  current level

Behaviour:
- Reset, asynchronous and active-high: X = INIT_X<<FRAC_BITS; Y = INIT_Y<<FRAC_BITS; level = 0; state = IDLE; dirLeft = 0; dropping = 0; edgeHit = 0; reachedBottom = 0. Reset asserted mid-drop or mid-march aborts immediately.
- Position registers are signed 32-bit fixed point. Outputs are the truncated integer part; they are registered, so they change the cycle after the startOfFrame pulse.
- States and transitions:
  - IDLE → MOV_RGT on `start`.
  - MOV_RGT: candidate nx = X + speed. If nx + (formationWidth<<F) ≥ RIGHT_BOUND<<F, then X = (RIGHT_BOUND − formationWidth)<<F and state → DROP_L. If `chgDir` is set, state → DROP_L with no clamp. Otherwise X = nx.
  - DROP_L: on each frame, Y += DROP_SPEED and the drop accumulator += DROP_SPEED. When the accumulator reaches DROP_PIX<<F, the last step is clipped to exact, the accumulator clears, and state → MOV_LFT.
  - MOV_LFT and DROP_R mirror MOV_RGT and DROP_L. The left test is nx ≤ LEFT_BOUND<<F, clamped to LEFT_BOUND.
  - Any state except IDLE → LANDED when the new Y ≥ BOTTOM_Y<<F. Y clamps to BOTTOM_Y, reachedBottom = 1, and the block holds until restart or reset.
- speed = BASE_X_SPEED + level × SPEED_INC.
- `speedUp` is accepted on any cycle, including in IDLE and LANDED. It takes effect on the next frame update.
- `chgDir` is ignored outside MOV_RGT and MOV_LFT. It is sampled only on the startOfFrame cycle and is not latched.
- `edgeHit` is asserted for the single cycle on which a MOV→DROP transition is registered.
- `dirLeft` updates on entry to DROP_L (→1) and DROP_R (→0).
- Priority on the same cycle: reset > restart > freeze > frame update.
  - `restart` clears reachedBottom.
  - `speedUp` together with an edge in the same cycle: both are applied.
  - `start` outside IDLE is ignored.
- Width rule: if formationWidth > RIGHT_BOUND − LEFT_BOUND, the right clamp still applies; the bench checks that no X underflow below LEFT_BOUND is output.

Optional Feature:
INVADER_MARCH_STEP_EN
- Defined: classic jerky march. Horizontal motion moves MARCH_PIX whole pixels once every max(1, MARCH_PERIOD − level) frames. Edge detection and clamping are unchanged. Drops occur in a single frame of DROP_PIX. The pacing counter freezes with `freeze` and clears on restart.
- Undefined: smooth fixed-point motion as described above; the MARCH_* parameters are unused.

Decomposition:
- Package invader_pkg holds:
  - the state enum (IDLE, MOV_RGT, DROP_L, MOV_LFT, DROP_R, LANDED);
  - typedef fixpos_t (signed 32-bit);
  - the FRAC_BITS default and a level_t typedef.
- One sub-module, invader_speed_ctrl, holds:
  - the saturating level counter;
  - the speed computation;
  - the march pacing counter under the macro.
- The top module keeps the FSM, position registers and bound logic.

Test Plan:
1. Reset, start, formationWidth=100, defaults → after 554 frames X=539, edgeHit pulses once, dropping=1.
2. Continue from 1 → 16 frames later Y=36, state MOV_LFT, dirLeft=1; X decreases by 60 sub-pixels/frame.
3. Three speedUp pulses then 64 frames in MOV_RGT from X=20 → X=128 (108 sub-pixels/frame); ten pulses → speedLevel=7, never wraps.
4. INIT_Y=395, chgDir pulse in MOV_RGT → drop; after 5 frames Y=400, reachedBottom=1, further frames leave X/Y unchanged; restart → X=20, Y=20, flag cleared, IDLE.
5. freeze held 30 frames mid-march → X/Y/state constant; release → motion resumes from the same value; chgDir during DROP_L → no effect.
6. Reset asserted mid-DROP_R, asynchronously between clocks → outputs return to INIT values immediately; the drop accumulator is cleared on the next start.
